// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, IF/ID register, redirects, stall and halt
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        jump,
  input  logic [25:0] jump_addr,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        halt_req,
  input  logic [31:0] im_instr,
  output logic [31:0] im_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus1,
  output logic        id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_plus1_q, id_pc_plus1_d;
  logic        id_valid_q, id_valid_d;
  logic        halted_q, halted_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        redirect;
  logic [31:0] br_target;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus1;

  // A redirect only comes from a real instruction sitting in ID; bubbles cannot steer fetch.
  assign redirect    = id_valid_q & (br_taken | jr | jump);
  assign br_target   = id_pc_plus1_q + {{16{br_offset[15]}}, br_offset};
  assign jump_target = {id_pc_plus1_q[31:26], jump_addr};
  assign pc_plus1    = pc_q + 32'd1;

  always_comb begin
    redirect_target = jump_target;
    if (br_taken) begin
      redirect_target = br_target;
    end else if (jr) begin
      redirect_target = jr_target;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_plus1_d = id_pc_plus1_q;
    id_valid_d    = id_valid_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      S_BOOT: begin
        id_valid_d = 1'b0;
        if (halt_req) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (halt_req) begin
          state_d    = S_HALT;
          halted_d   = 1'b1;
          id_valid_d = 1'b0;
        end else if (redirect) begin
          // Redirect outranks stall: the redirecting instruction is older than the hazard.
          pc_d       = redirect_target;
          id_valid_d = 1'b0;
          id_instr_d = 32'd0;
        end else if (!stall) begin
          id_instr_d    = im_instr;
          id_pc_plus1_d = pc_plus1;
          id_valid_d    = 1'b1;
          pc_d          = pc_plus1;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      id_instr_q    <= 32'd0;
      id_pc_plus1_q <= 32'd0;
      id_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_plus1_q <= id_pc_plus1_d;
      id_valid_q    <= id_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign im_pc       = pc_q;
  assign id_instr    = id_instr_q;
  assign id_pc_plus1 = id_pc_plus1_q;
  assign id_valid    = id_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst1_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_offset = 16'd0;
  logic        jump = 1'b0;
  logic [25:0] jump_addr = 26'd0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = 32'd0;
  logic        halt_req = 1'b0;

  logic [31:0] im_instr0, im_pc0, id_instr0, id_pc_plus10, fetch_count0;
  logic        id_valid0, halted0;
  logic [31:0] im_instr1, im_pc1, id_instr1, id_pc_plus11, fetch_count1;
  logic        id_valid1, halted1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mw(input logic [7:0] a);
    if (a == 8'd0) return 32'h2001_0005;
    return {24'hC0DE00, a};
  endfunction

  assign im_instr0 = mw(im_pc0[7:0]);
  assign im_instr1 = mw(im_pc1[7:0]);

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
    .jump(jump), .jump_addr(jump_addr), .jr(jr), .jr_target(jr_target), .halt_req(halt_req),
    .im_instr(im_instr0), .im_pc(im_pc0), .id_instr(id_instr0), .id_pc_plus1(id_pc_plus10),
    .id_valid(id_valid0), .halted(halted0), .fetch_count(fetch_count0)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut1 (
    .clk(clk), .rst_n(rst1_n), .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
    .jump(jump), .jump_addr(jump_addr), .jr(jr), .jr_target(jr_target), .halt_req(halt_req),
    .im_instr(im_instr1), .im_pc(im_pc1), .id_instr(id_instr1), .id_pc_plus1(id_pc_plus11),
    .id_valid(id_valid1), .halted(halted1), .fetch_count(fetch_count1)
  );

  typedef struct {
    logic        stall, br, jmp, jr, halt;
    logic [15:0] off;
    logic [25:0] ja;
    logic [31:0] jt;
    logic [31:0] e_pc, e_instr, e_pp1, e_fc;
    logic        e_valid, e_halted, c_pp1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic s, input logic b, input logic [15:0] off, input logic j, input logic [25:0] ja,
    input logic r, input logic [31:0] jt, input logic h,
    input logic [31:0] pc, input logic v, input logic [31:0] ins, input logic [31:0] pp1,
    input logic cp, input logic [31:0] fc, input logic hd);
    vec_t x;
    x.stall = s; x.br = b; x.off = off; x.jmp = j; x.ja = ja; x.jr = r; x.jt = jt; x.halt = h;
    x.e_pc = pc; x.e_valid = v; x.e_instr = ins; x.e_pp1 = pp1; x.c_pp1 = cp; x.e_fc = fc;
    x.e_halted = hd;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; br_taken = 0; br_offset = 0; jump = 0; jump_addr = 0; jr = 0; jr_target = 0;
    halt_req = 0;
  endtask

  initial begin
    // stall br off jmp ja jr jt halt | pc valid instr pp1 chk_pp1 fc halted
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'd0, 0, 32'd0,     32'd0, 1, 32'd0, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'd1, 1, mw(8'd0),  32'd1, 1, 32'd1, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'd2, 1, mw(8'd1),  32'd2, 1, 32'd2, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'd3, 1, mw(8'd2),  32'd3, 1, 32'd3, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'd4, 1, mw(8'd3),  32'd4, 1, 32'd4, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 32'd4, 1, mw(8'd3),  32'd4, 1, 32'd4, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 32'd4, 1, mw(8'd3),  32'd4, 1, 32'd4, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 32'd4, 1, mw(8'd3),  32'd4, 1, 32'd4, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'd5, 1, mw(8'd4),  32'd5, 1, 32'd5, 0));
    // backward branch 5 + (-3) = 2, then the target word after one bubble
    tbl.push_back(mk(0,1,16'hFFFD,0,0,0,0,0, 32'd2, 0, 32'd0, 32'd5, 0, 32'd5, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'd3, 1, mw(8'd2),  32'd3, 1, 32'd6, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'd4, 1, mw(8'd3),  32'd4, 1, 32'd7, 0));
    // branch under stall still redirects; repeat with id_valid=0 is ignored and stall holds
    tbl.push_back(mk(1,1,16'hFFFD,0,0,0,0,0, 32'd1, 0, 32'd0, 32'd4, 0, 32'd7, 0));
    tbl.push_back(mk(1,1,16'hFFFD,0,0,0,0,0, 32'd1, 0, 32'd0, 32'd4, 0, 32'd7, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'd2, 1, mw(8'd1),  32'd2, 1, 32'd8, 0));
    tbl.push_back(mk(0,0,0,0,0,1,32'h1000_0004,0, 32'h1000_0004, 0, 32'd0, 32'd2, 0, 32'd8, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h1000_0005, 1, mw(8'h04), 32'h1000_0005, 1, 32'd9, 0));
    tbl.push_back(mk(0,0,0,1,26'h40,0,0,0, 32'h1000_0040, 0, 32'd0, 32'h1000_0005, 0, 32'd9, 0));
    tbl.push_back(mk(0,0,0,1,26'h80,0,0,0, 32'h1000_0041, 1, mw(8'h40), 32'h1000_0041, 1, 32'd10, 0));
    tbl.push_back(mk(0,1,16'h0010,1,26'h80,0,0,0, 32'h1000_0051, 0, 32'd0, 32'h1000_0041, 0, 32'd10, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h1000_0052, 1, mw(8'h51), 32'h1000_0052, 1, 32'd11, 0));
    tbl.push_back(mk(0,0,0,1,26'h5,1,32'h77,0, 32'h77, 0, 32'd0, 32'h1000_0052, 0, 32'd11, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h78, 1, mw(8'h77), 32'h78, 1, 32'd12, 0));
    // halt beats stall and redirect, then everything is frozen
    tbl.push_back(mk(1,1,16'h0004,0,0,0,0,1, 32'h78, 0, mw(8'h77), 32'h78, 1, 32'd12, 1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h78, 0, mw(8'h77), 32'h78, 1, 32'd12, 1));
    tbl.push_back(mk(0,0,0,1,26'h9,1,32'h5,0, 32'h78, 0, mw(8'h77), 32'h78, 1, 32'd12, 1));

    idle_inputs();
    #12;
    chk("reset_pc", im_pc0, 32'd0);
    chk("reset_valid", {31'd0, id_valid0}, 32'd0);
    chk("reset_instr", id_instr0, 32'd0);
    chk("reset_fc", fetch_count0, 32'd0);
    chk("reset_pc_hi", im_pc1, 32'hFFFF_FFFF);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      stall = tbl[i].stall; br_taken = tbl[i].br; br_offset = tbl[i].off;
      jump = tbl[i].jmp; jump_addr = tbl[i].ja; jr = tbl[i].jr; jr_target = tbl[i].jt;
      halt_req = tbl[i].halt;
      step();
      chk($sformatf("v%0d_pc", i), im_pc0, tbl[i].e_pc);
      chk($sformatf("v%0d_valid", i), {31'd0, id_valid0}, {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d_instr", i), id_instr0, tbl[i].e_instr);
      if (tbl[i].c_pp1) chk($sformatf("v%0d_pp1", i), id_pc_plus10, tbl[i].e_pp1);
      chk($sformatf("v%0d_fc", i), fetch_count0, tbl[i].e_fc);
      chk($sformatf("v%0d_halted", i), {31'd0, halted0}, {31'd0, tbl[i].e_halted});
    end
    idle_inputs();

    // asynchronous reset between edges takes effect immediately
    #2 rst_n = 1'b0;
    #1;
    chk("async_pc", im_pc0, 32'd0);
    chk("async_halted", {31'd0, halted0}, 32'd0);
    chk("async_fc", fetch_count0, 32'd0);
    chk("async_instr", id_instr0, 32'd0);
    chk("async_pp1", id_pc_plus10, 32'd0);

    // halt honoured in BOOT
    #2 rst_n = 1'b1;
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("boot_halt", {31'd0, halted0}, 32'd1);
    chk("boot_halt_pc", im_pc0, 32'd0);
    step();
    chk("boot_halt_frozen_pc", im_pc0, 32'd0);
    chk("boot_halt_valid", {31'd0, id_valid0}, 32'd0);

    // PC wrap from 32'hFFFF_FFFF
    rst1_n = 1'b1;
    step();
    chk("wrap_boot_pc", im_pc1, 32'hFFFF_FFFF);
    chk("wrap_boot_valid", {31'd0, id_valid1}, 32'd0);
    step();
    chk("wrap_pc", im_pc1, 32'd0);
    chk("wrap_pp1", id_pc_plus11, 32'd0);
    chk("wrap_instr", id_instr1, mw(8'hFF));
    chk("wrap_fc", fetch_count1, 32'd1);
    chk("wrap_valid", {31'd0, id_valid1}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
